// File: rtl/mem_pkg.sv
// Shared memory-path constants and the store-buffer entry layout.
package mem_pkg;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned WORD_LSB = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-path, forwarding and DM-write signals of the store buffer.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    import mem_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [PC_W-1:0]   st_pc;
    logic              drain_en;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr_byte;
    logic [DATA_W-1:0] mem_data;
    logic [PC_W-1:0]   mem_pc;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output st_valid, st_addr, st_data, st_pc, drain_en, ld_addr,
        input  st_ready, ld_hit, ld_data, mem_write, mem_addr_byte, mem_data, mem_pc,
               count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, drain_en, ld_addr,
        output st_ready, ld_hit, ld_data, mem_write, mem_addr_byte, mem_data, mem_pc,
               count, empty, full
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: youngest valid entry whose word index matches the load.
module store_buffer_fwd
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  sb_entry_t         i_entries [DEPTH],
    input  logic [PTR_W-1:0]  i_rd_ptr,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [ADDR_W-1:0] i_ld_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < i_count) &&
                (i_entries[w_idx].addr[ADDR_W-1:WORD_LSB] == i_ld_addr[ADDR_W-1:WORD_LSB])) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-store FIFO between the MEM-stage store path and DM; drains one entry per cycle.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    sb_entry_t w_head;
    sb_entry_t w_new;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = sb.st_valid && !w_full;
    assign w_pop   = !w_empty && sb.drain_en;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_new   = '{addr: sb.st_addr, data: sb.st_data, pc: sb.st_pc};

    assign sb.st_ready     = !w_full;
    assign sb.mem_write    = w_pop;
    assign sb.mem_addr_byte = w_empty ? '0 : w_head.addr;
    assign sb.mem_data     = w_empty ? '0 : w_head.data;
    assign sb.mem_pc       = w_empty ? '0 : w_head.pc;
    assign sb.count        = r_count;
    assign sb.empty        = w_empty;
    assign sb.full         = w_full;

    // Entry contents need no reset: validity is defined purely by rd_ptr and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .i_entries (r_mem),
        .i_rd_ptr  (r_rd_ptr),
        .i_count   (r_count),
        .i_ld_addr (sb.ld_addr),
        .o_hit     (sb.ld_hit),
        .o_data    (sb.ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected DM writes queued at issue, checked by a monitor.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

    store_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    sb_entry_t exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [PC_W-1:0] p);
        sb_if.st_valid = 1'b1;
        sb_if.st_addr  = a;
        sb_if.st_data  = d;
        sb_if.st_pc    = p;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [PC_W-1:0] p);
        exp_q.push_back('{addr: a, data: d, pc: p});
    endtask

    // Every DM write must match the oldest outstanding expected store.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (sb_if.mem_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             sb_if.mem_addr_byte, sb_if.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(sb_if.mem_addr_byte), 64'(e.addr));
                    chk("wr_data", 64'(sb_if.mem_data), 64'(e.data));
                    chk("wr_pc", 64'(sb_if.mem_pc), 64'(e.pc));
                end
            end
        end
    end

    initial begin
        sb_if.st_valid = 1'b0;
        sb_if.st_addr  = '0;
        sb_if.st_data  = '0;
        sb_if.st_pc    = '0;
        sb_if.drain_en = 1'b0;
        sb_if.ld_addr  = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_empty", 64'(sb_if.empty), 64'd1);
        chk("rst_full", 64'(sb_if.full), 64'd0);
        chk("rst_ready", 64'(sb_if.st_ready), 64'd1);
        chk("rst_mem_write", 64'(sb_if.mem_write), 64'd0);
        chk("rst_ld_hit", 64'(sb_if.ld_hit), 64'd0);
        chk("rst_count", 64'(sb_if.count), 64'd0);

        // Single store, drained in the next cycle
        sb_if.drain_en = 1'b1;
        set_store(14'h0010, 32'hDEADBEEF, 32'h00003000);
        expect_write(14'h0010, 32'hDEADBEEF, 32'h00003000);
        tick();
        sb_if.st_valid = 1'b0;
        chk("t1_mem_write", 64'(sb_if.mem_write), 64'd1);
        chk("t1_mem_addr", 64'(sb_if.mem_addr_byte), 64'h0010);
        tick();
        chk("t1_empty", 64'(sb_if.empty), 64'd1);
        chk("t1_mem_write_off", 64'(sb_if.mem_write), 64'd0);
        chk("t1_mem_data_zero", 64'(sb_if.mem_data), 64'd0);

        // Fill to full, reject a fifth, then drain in order
        sb_if.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(14'(4 * i), 32'h1000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i));
            expect_write(14'(4 * i), 32'h1000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i));
            tick();
        end
        chk("t2_full", 64'(sb_if.full), 64'd1);
        chk("t2_ready", 64'(sb_if.st_ready), 64'd0);
        chk("t2_count", 64'(sb_if.count), 64'd4);
        set_store(14'h0100, 32'hBAD0BAD0, 32'h0000_9999);
        tick();
        sb_if.st_valid = 1'b0;
        chk("t2_count_after_reject", 64'(sb_if.count), 64'd4);
        sb_if.drain_en = 1'b1;
        repeat (4) tick();
        chk("t2_drained", 64'(sb_if.empty), 64'd1);

        // Forwarding: youngest match wins, word granularity
        sb_if.drain_en = 1'b0;
        set_store(14'h0020, 32'h11111111, 32'h0000_2000);
        expect_write(14'h0020, 32'h11111111, 32'h0000_2000);
        tick();
        set_store(14'h0022, 32'h22222222, 32'h0000_2004);
        expect_write(14'h0022, 32'h22222222, 32'h0000_2004);
        sb_if.ld_addr = 14'h0021;
        #1;
        chk("t3_pending_not_visible", 64'(sb_if.ld_data), 64'h11111111);
        tick();
        sb_if.st_valid = 1'b0;
        chk("t3_hit", 64'(sb_if.ld_hit), 64'd1);
        chk("t3_data_youngest", 64'(sb_if.ld_data), 64'h22222222);
        sb_if.ld_addr = 14'h0024;
        #1;
        chk("t3_miss", 64'(sb_if.ld_hit), 64'd0);
        chk("t3_miss_data", 64'(sb_if.ld_data), 64'd0);
        sb_if.drain_en = 1'b1;
        repeat (2) tick();
        chk("t3_drained", 64'(sb_if.empty), 64'd1);

        // Steady state: push every cycle while draining; pointers wrap
        for (int i = 0; i < 10; i++) begin
            set_store(14'h0040 + 14'(4 * i), 32'hA000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i));
            expect_write(14'h0040 + 14'(4 * i), 32'hA000_0000 + 32'(i),
                         32'h0000_4000 + 32'(4 * i));
            tick();
            chk("t4_count", 64'(sb_if.count), 64'd1);
        end
        sb_if.st_valid = 1'b0;
        tick();
        chk("t4_drained", 64'(sb_if.empty), 64'd1);

        // Full with drain: push rejected, pop still happens
        sb_if.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(14'h0080 + 14'(4 * i), 32'hC000_0000 + 32'(i), 32'h0000_6000 + 32'(i));
            expect_write(14'h0080 + 14'(4 * i), 32'hC000_0000 + 32'(i), 32'h0000_6000 + 32'(i));
            tick();
        end
        set_store(14'h0200, 32'hBAD1BAD1, 32'h0000_7777);
        sb_if.drain_en = 1'b1;
        #1;
        chk("t6_ready_full", 64'(sb_if.st_ready), 64'd0);
        tick();
        sb_if.st_valid = 1'b0;
        chk("t6_count", 64'(sb_if.count), 64'd3);
        repeat (3) tick();
        chk("t6_drained", 64'(sb_if.empty), 64'd1);

        // Reset discards buffered entries
        sb_if.drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(14'h0300 + 14'(4 * i), 32'hEEEE_0000 + 32'(i), 32'h0000_8000);
            tick();
        end
        sb_if.st_valid = 1'b0;
        chk("t5_count_pre", 64'(sb_if.count), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_count", 64'(sb_if.count), 64'd0);
        chk("t5_empty", 64'(sb_if.empty), 64'd1);
        sb_if.drain_en = 1'b1;
        #1;
        chk("t5_mem_write", 64'(sb_if.mem_write), 64'd0);
        repeat (3) tick();
        chk("t5_still_empty", 64'(sb_if.empty), 64'd1);

        tick();
        chk("sb_outstanding", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-store FIFO between the MEM-stage store path and the data memory (DM): accepts `sw` requests from the datapath and drains one per cycle into DM's write port.
- Gives store-to-load forwarding so loads see buffered, not-yet-written data.
- Drives DM's mem_write / mem_addr_byte / mem_data / pc inputs directly; DM's trace print therefore happens at drain time, tagged with the originating store's pc.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- ADDR_W, 14, byte-address width, matching the DM address port.
- DATA_W, 32, store data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept this cycle.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data.
- st_pc  in  32  pc of the store instruction.
- drain_en  in  1  permission to issue a DM write this cycle.
- ld_addr  in  ADDR_W  load byte address for forwarding lookup.
- ld_hit  out  1  a buffered entry matches ld_addr's word.
- ld_data  out  DATA_W  data of the youngest matching entry.
- mem_write  out  1  to DM mem_write.
- mem_addr_byte  out  ADDR_W  to DM mem_addr_byte.
- mem_data  out  DATA_W  to DM mem_data.
- mem_pc  out  32  to DM pc.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Storage: circular array of {addr, data, pc}; head pointer (rd_ptr), tail pointer (wr_ptr), count register. Pointers are clog2(DEPTH) bits and wrap naturally.
- Reset:
  - rd_ptr=0, wr_ptr=0, count=0; entries are invalidated, not cleared.
  - Outputs after reset: mem_write=0, ld_hit=0, empty=1, full=0, st_ready=1.
  - Reset mid-drain discards all entries; no further DM write occurs.
- Push:
  - st_ready = !full, derived from registered count only; there is no pass-through when full, even if a pop happens that cycle.
  - A push occurs on a clk edge when st_valid && st_ready. The entry is written at wr_ptr, then wr_ptr increments.
  - st_valid while full is ignored; the upstream stage must stall.
- Pop / drain:
  - mem_write = !empty && drain_en.
  - mem_addr_byte, mem_data and mem_pc are driven combinationally from the head entry. They are 0 when empty.
  - On an edge where mem_write is high: rd_ptr increments and DM commits the head entry at that same edge.
  - Latency: a store pushed into an empty buffer at edge N is presented at DM in the following cycle and committed at edge N+1, given drain_en.
- Simultaneous push and pop: count unchanged, both pointers advance. Pushing into an empty buffer and popping in the same cycle is impossible, because the head is invalid until the edge.
- Count update: count <= count + push − pop.
  - count never exceeds DEPTH and never goes below 0.
  - Pointer wrap at DEPTH−1 → 0 requires no special casing.
- Forwarding (combinational):
  - Compare ld_addr[ADDR_W-1:2] against addr[ADDR_W-1:2] of all valid entries, i.e. the count entries starting at rd_ptr.
  - ld_hit=1 if any entry matches. ld_data comes from the youngest match (closest to wr_ptr); otherwise ld_data=0.
  - The store being pushed in the same cycle is not visible.
  - The head being popped that cycle is still visible. This is consistent, because DM holds the same value after the edge.
- mem_addr_byte carries the full byte address; bits [1:0] are preserved, and DM ignores them.
- No coalescing of stores to the same word; every push produces exactly one DM write, in program order.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W constants.
  - Word-index slice helper constant WORD_LSB=2.
  - The sb_entry_t struct {addr, data, pc}.
- One natural sub-module, store_buffer_fwd: the combinational youngest-match priority search over the entry array given rd_ptr and count.
- FIFO control and storage stay in store_buffer.

Test Plan:
- Reset, then push st_addr=0x0010, st_data=0xDEADBEEF, st_pc=0x00003000 with drain_en=1 → next cycle mem_write=1, mem_addr_byte=0x0010, mem_data=0xDEADBEEF, mem_pc=0x00003000; the following cycle empty=1, mem_write=0.
- drain_en=0, push 4 stores to addresses 0x0,0x4,0x8,0xC → full=1, st_ready=0, count=4. A fifth st_valid is ignored. Set drain_en=1 → four DM writes in order 0x0,0x4,0x8,0xC.
- Hold drain_en=0, push 0x0020←0x11111111 then 0x0022←0x22222222. Query ld_addr=0x0021 → ld_hit=1, ld_data=0x22222222 (youngest). Query 0x0024 → ld_hit=0, ld_data=0.
- Steady state with drain_en=1 and st_valid every cycle for 10 cycles → count stays at 1. Pointers wrap past DEPTH−1 with no lost or duplicated writes; 10 DM writes occur in order.
- Fill 3 entries with drain_en=0, assert reset for one cycle → count=0, empty=1, mem_write=0. Subsequent drain_en=1 produces no DM write.
- Push while full and draining in the same cycle → push rejected (st_ready=0), pop occurs, count goes 4→3.
